// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle MUL controller for the EX stage; shift-add over operand B chunks.
// Latency: accept cycle + MULT_CYCLES busy cycles stalled, result_valid on the following cycle.
// Backpressure: holds the pipeline via stall while running; result is presented once, unqualified otherwise.
//
// Ports:
//   clk, arst_n           clock and synchronous active-low reset
//   mul_req, kill         request from EX, abort from the hazard unit
//   operand_a/b, rd_in    operands and destination register (sampled only on accept)
//   stall, busy           pipeline freeze and BUSY-state indication
//   result_valid, result, rd_out   one-cycle result strobe with product low word and tag
module mul_sequencer #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              mul_req,
    input  logic              kill,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        rd_out
);

    // DATA_W must be a multiple of MULT_CYCLES.
    localparam int CHUNK_W = DATA_W / MULT_CYCLES;
    localparam int CNT_W   = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_rd_out;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_base;
    logic [DATA_W-1:0] w_chunk_ext;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_acc_nxt;

    assign w_accept = (r_state == IDLE) && mul_req && !kill;
    assign w_last   = (r_count == CNT_W'(MULT_CYCLES - 1));

    // Bit offset of the current multiplier chunk; also the weight of its partial product.
    assign w_base      = 32'(r_count) * 32'(CHUNK_W);
    assign w_chunk_ext = DATA_W'(CHUNK_W'(r_b >> w_base));
    // Only the low DATA_W bits of the product are ever needed, so truncation is intended.
    assign w_prod      = r_a * w_chunk_ext;
    assign w_acc_nxt   = r_acc + (w_prod << w_base);

    assign result = r_result;
    assign rd_out = r_rd_out;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            IDLE: begin
                stall = mul_req && !kill;
                if (w_accept) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                // A kill releases the pipeline in the same cycle so the flush can proceed.
                stall = !kill;
                if (kill) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                result_valid = !kill;
                // Never re-accept here: the requesting instruction leaves EX this cycle.
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= operand_a;
                r_b     <= operand_b;
                r_rd    <= rd_in;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == BUSY && !kill) begin
                r_acc   <= w_acc_nxt;
                r_count <= r_count + CNT_W'(1);
                // Result registers change only when a new product completes, so they
                // hold the last delivered value between operations.
                if (w_last) begin
                    r_result <= w_acc_nxt;
                    r_rd_out <= r_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    logic        clk;
    logic        arst_n;
    logic        mul_req;
    logic        kill;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mul_sequencer #(.DATA_W(32), .MULT_CYCLES(4)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .mul_req      (mul_req),
        .kill         (kill),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit later; any result strobe is
    // matched against the oldest outstanding expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (result_valid) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("rd_out", 64'(rd_out), 64'(e.rd));
            end
        end
    endtask

    // Issue a MUL and wait (bounded) for its result strobe.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int exp_ticks, input bit hold, input bit scramble);
        exp_t        e;
        logic [31:0] p;
        int          n;
        bit          got;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        mul_req   = 1'b1;
        p         = a * b;
        e.res     = p;
        e.rd      = rd;
        sb.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (scramble && n == 2) begin
                operand_a = $urandom;
                operand_b = $urandom;
            end
            if (result_valid) begin
                got = 1'b1;
                chk("done_stall", 64'(stall), 64'd0);
            end else begin
                chk("run_stall", 64'(stall), 64'd1);
            end
        end
        chk("latency", 64'(n), 64'(exp_ticks));
        if (!hold) mul_req = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_stall"}, 64'(stall), 64'd0);
        chk({tag, "_valid"}, 64'(result_valid), 64'd0);
    endtask

    initial begin
        arst_n    = 1'b0;
        mul_req   = 1'b0;
        kill      = 1'b0;
        operand_a = '0;
        operand_b = '0;
        rd_in     = '0;

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_rd", 64'(rd_out), 64'd0);
        arst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // 7*6 -> 42 to rd 5; stall is combinational in the accept cycle.
        // Operands are scrambled in the 2nd busy cycle and must not matter.
        operand_a = 32'd7;
        operand_b = 32'd6;
        rd_in     = 5'd5;
        mul_req   = 1'b1;
        #1;
        chk("accept_stall", 64'(stall), 64'd1);
        mul_op(32'd7, 32'd6, 5'd5, 5, 1'b0, 1'b1);
        tick();
        chk_idle("after_42");

        // Corner operands
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 5, 1'b0, 1'b0);
        tick();
        mul_op(32'h1234_5678, 32'h0000_0010, 5'd31, 5, 1'b0, 1'b0);
        tick();
        mul_op(32'h0, 32'hDEAD_BEEF, 5'd3, 5, 1'b0, 1'b0);
        tick();

        // Back to back: the second MUL is presented during DONE of the first
        mul_op(32'd3, 32'd4, 5'd1, 5, 1'b1, 1'b0);
        mul_op(32'h0001_0000, 32'h0001_0000, 5'd2, 6, 1'b0, 1'b0);
        tick();
        chk_idle("after_b2b");
        tick();
        chk("b2b_drained", 64'(sb.size()), 64'd0);

        // Kill in IDLE blocks acceptance
        operand_a = 32'd11;
        operand_b = 32'd11;
        rd_in     = 5'd4;
        mul_req   = 1'b1;
        kill      = 1'b1;
        #1;
        chk("idle_kill_stall", 64'(stall), 64'd0);
        tick();
        chk("idle_kill_busy", 64'(busy), 64'd0);
        kill = 1'b0;

        // Kill in the 3rd busy cycle: no result may follow
        operand_a = 32'd5;
        operand_b = 32'd5;
        rd_in     = 5'd6;
        mul_req   = 1'b1;
        tick();
        mul_req = 1'b0;
        tick();
        tick();
        chk("pre_kill_busy", 64'(busy), 64'd1);
        kill = 1'b1;
        #1;
        chk("kill_stall", 64'(stall), 64'd0);
        chk("kill_valid", 64'(result_valid), 64'd0);
        tick();
        kill = 1'b0;
        chk_idle("post_kill");
        for (int i = 0; i < 4; i++) tick();
        chk_idle("kill_quiet");
        mul_op(32'd2, 32'd2, 5'd8, 5, 1'b0, 1'b0);
        tick();

        // Reset during BUSY, then restart with the same request
        operand_a = 32'd9;
        operand_b = 32'd9;
        rd_in     = 5'd7;
        mul_req   = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        arst_n  = 1'b0;
        mul_req = 1'b0;
        tick();
        chk_idle("mid_reset");
        chk("mid_reset_result", 64'(result), 64'd0);
        chk("mid_reset_rd", 64'(rd_out), 64'd0);
        arst_n = 1'b1;
        tick();
        chk_idle("mid_reset_quiet");
        mul_op(32'd9, 32'd9, 5'd7, 5, 1'b0, 1'b0);
        tick();
        chk_idle("final");
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the MUL instruction in the EX stage of the 5-stage RISC-V pipeline.
- Accepts one multiply request and computes the low DATA_W bits of the product with a shift-add datapath that consumes one DATA_W/MULT_CYCLES-bit chunk of operand B per cycle.
- Drives the pipeline stall while the multiply runs, then presents the result for exactly one cycle so EX/MEM can capture it.

Parameters:
- DATA_W, 32, operand and result width.
- MULT_CYCLES, 4, number of BUSY iterations. DATA_W must be divisible by MULT_CYCLES; CHUNK_W = DATA_W/MULT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- arst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- mul_req  input  1  EX stage holds a valid MUL instruction.
- kill  input  1  abort the current operation (exception or flush from the hazard unit).
- operand_a  input  DATA_W  multiplicand from the EX forwarding mux.
- operand_b  input  DATA_W  multiplier from the EX forwarding mux.
- rd_in  input  5  destination register of the requesting instruction.
- stall  output  1  freeze PC, IF/ID, ID/EX; insert a bubble into EX/MEM.
- busy  output  1  state is BUSY.
- result_valid  output  1  result and rd_out are valid this cycle.
- result  output  DATA_W  low DATA_W bits of operand_a*operand_b.
- rd_out  output  5  destination register tagged with result.

Behaviour:
- Reset (arst_n=0 at a clock edge):
  - state=IDLE; count=0; accumulator, latched operands, result and rd_out = 0.
  - Reset overrides all other inputs, including mid-operation; no result_valid follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = mul_req & ~kill (combinational).
  - On mul_req & ~kill: latch A=operand_a, B=operand_b, rd=rd_in; acc=0; count=0; go to BUSY.
- BUSY:
  - stall=1; busy=1.
  - Each cycle: acc = acc + ((A * B[count*CHUNK_W +: CHUNK_W]) << (count*CHUNK_W)), truncated to DATA_W. count increments.
  - After the iteration with count=MULT_CYCLES-1, go to DONE.
  - Operand inputs are ignored in BUSY; only the latched copies are used.
- DONE:
  - Lasts exactly one cycle. result_valid=1; result=acc; rd_out=rd; stall=0.
  - Unconditionally returns to IDLE, even if mul_req is still high. The pipeline advances this cycle, so the same instruction is never restarted.
- Latency: accept cycle plus MULT_CYCLES BUSY cycles = 5 stall cycles at the default; result_valid in the 6th cycle.
- Back-to-back MULs: a second MUL enters EX during DONE and is accepted in the following IDLE cycle. Throughput is one MUL per MULT_CYCLES+2 cycles.
- kill:
  - In BUSY or DONE: return to IDLE next edge; result_valid forced 0 in that cycle; stall=0 in the kill cycle.
  - In IDLE: blocks acceptance.
- result and rd_out hold their last value when result_valid=0; downstream must qualify with result_valid.
- Arithmetic is unsigned modulo 2^DATA_W. This is identical to signed MUL low-word semantics.
- Multiply-by-zero still takes the full latency; there is no early termination.

Test Plan:
- Reset, then operand_a=7, operand_b=6, rd_in=5, mul_req held until stall drops -> stall high 5 cycles; result_valid=1 in cycle 6 with result=42, rd_out=5; stall=0 in that cycle.
- operand_a=0xFFFFFFFF, operand_b=0xFFFFFFFF -> result=0x00000001. operand_a=0x12345678, operand_b=0x00000010 -> result=0x23456780.
- Two MULs back to back (3*4 to rd=1, then 0x10000*0x10000 to rd=2) -> first result 12 with rd_out=1, second result 0x00000000 with rd_out=2. The second is accepted in the cycle after the first DONE. No duplicate result_valid.
- During the first operation, change operand_a/operand_b in the second BUSY cycle -> result unchanged, because it is computed from the latched operands.
- Assert kill in the 3rd BUSY cycle -> next cycle IDLE, stall=0, result_valid never pulses. A fresh 2*2 then returns 4.
- Drive arst_n=0 for one edge during BUSY -> IDLE, all outputs 0, stall=0 after the edge. Hold mul_req=1 with mul_req and operands unchanged -> the operation restarts and completes normally.
